// File: rtl/mem_pkg.sv
// Shared constants and types for the clearable dual-port memory bank.
package mem_pkg;
  localparam int MEM_DATA_W = 8;
  localparam int MEM_ADDR_W = 3;

  localparam int BYP_NEW = 1;
  localparam int BYP_OLD = 0;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } mem_state_t;
endpackage

// File: rtl/mem_array_2p.sv
// Reset-free storage array: one synchronous write port, one combinational read port.
module mem_array_2p #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              i_clock,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge i_clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/mem_bank_clr.sv
// Dual-port memory bank with registered read, collision policy and a
// one-word-per-cycle hardware clear sweep run after reset and on request.
module mem_bank_clr
  import mem_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W,
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int BYPASS = BYP_NEW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  output logic              busy,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);
  mem_state_t        r_state;
  logic [ADDR_W-1:0] r_cptr;
  logic              r_busy;
  logic [DATA_W-1:0] r_rdata_p1;
  logic              r_rvalid_p1;

  logic              w_idle;
  logic              w_user_wr;
  logic              w_user_rd;
  logic              w_collide;
  logic              w_arr_we;
  logic [ADDR_W-1:0] w_arr_waddr;
  logic [DATA_W-1:0] w_arr_wdata;
  logic [DATA_W-1:0] w_arr_rdata;
  logic [DATA_W-1:0] w_rd_next;

  function automatic logic [DATA_W-1:0] f_rd_sel(
    input logic              collide,
    input logic [DATA_W-1:0] new_d,
    input logic [DATA_W-1:0] old_d
  );
    if (!collide || BYPASS == BYP_OLD) begin
      return old_d;
    end
    return new_d;
  endfunction

  // A clear request in IDLE takes priority over any user access that cycle.
  assign w_idle    = (r_state == IDLE);
  assign w_user_wr = w_idle && !clear && we;
  assign w_user_rd = w_idle && !clear && re;
  assign w_collide = w_user_wr && (waddr == raddr);

  assign w_arr_we    = !w_idle || w_user_wr;
  assign w_arr_waddr = w_idle ? waddr : r_cptr;
  assign w_arr_wdata = w_idle ? wdata : '0;

  mem_array_2p #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .i_clock (clock),
    .i_we    (w_arr_we),
    .i_waddr (w_arr_waddr),
    .i_wdata (w_arr_wdata),
    .i_raddr (raddr),
    .o_rdata (w_arr_rdata)
  );

  assign w_rd_next = f_rd_sel(w_collide, wdata, w_arr_rdata);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= CLEAR;
      r_cptr  <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        CLEAR: begin
          // Terminal compare stops the sweep before the pointer can wrap.
          if (r_cptr == '1) begin
            r_state <= IDLE;
            r_cptr  <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cptr <= r_cptr + ADDR_W'(1);
          end
        end
        IDLE: begin
          if (clear) begin
            r_state <= CLEAR;
            r_cptr  <= '0;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= CLEAR;
          r_cptr  <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  // Read stage p1: registered data and its strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rdata_p1  <= '0;
      r_rvalid_p1 <= 1'b0;
    end else begin
      r_rvalid_p1 <= w_user_rd;
      if (w_user_rd) begin
        r_rdata_p1 <= w_rd_next;
      end
    end
  end

  assign busy   = r_busy;
  assign rdata  = r_rdata_p1;
  assign rvalid = r_rvalid_p1;
endmodule

// File: tb/tb_mem_bank_clr.sv
// Directed and randomized bench for mem_bank_clr against a word-level reference model.
module tb_mem_bank_clr;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  // 8x8 pair: identical stimulus, opposite collision policies
  logic       rst_a = 1'b0, clr_a = 1'b0, we_a = 1'b0, re_a = 1'b0;
  logic [2:0] wa_a = 3'd0, ra_a = 3'd0;
  logic [7:0] wd_a = 8'h00;
  logic       busy_a, rv_a, busy_b, rv_b;
  logic [7:0] rd_a, rd_b;

  // 16x32 instance
  logic        rst_c = 1'b0, clr_c = 1'b0, we_c = 1'b0, re_c = 1'b0;
  logic [4:0]  wa_c = 5'd0, ra_c = 5'd0;
  logic [15:0] wd_c = 16'h0000;
  logic        busy_c, rv_c;
  logic [15:0] rd_c;

  mem_bank_clr #(.DATA_W(8), .ADDR_W(3), .BYPASS(1)) dut_a (
    .clock(clock), .reset(rst_a), .clear(clr_a), .busy(busy_a),
    .we(we_a), .waddr(wa_a), .wdata(wd_a),
    .re(re_a), .raddr(ra_a), .rdata(rd_a), .rvalid(rv_a));

  mem_bank_clr #(.DATA_W(8), .ADDR_W(3), .BYPASS(0)) dut_b (
    .clock(clock), .reset(rst_a), .clear(clr_a), .busy(busy_b),
    .we(we_a), .waddr(wa_a), .wdata(wd_a),
    .re(re_a), .raddr(ra_a), .rdata(rd_b), .rvalid(rv_b));

  mem_bank_clr #(.DATA_W(16), .ADDR_W(5), .BYPASS(1)) dut_c (
    .clock(clock), .reset(rst_c), .clear(clr_c), .busy(busy_c),
    .we(we_c), .waddr(wa_c), .wdata(wd_c),
    .re(re_c), .raddr(ra_c), .rdata(rd_c), .rvalid(rv_c));

  int n_checks = 0;
  int n_pass   = 0;
  int n_step   = 0;

  // Reference model: a clear wipes the whole store at once and then simply
  // blocks the ports for DEPTH edges.
  logic [7:0]  m8 [8];
  int          sl8 = 0;
  logic [7:0]  e_rda = 8'h00, e_rdb = 8'h00;
  logic        e_rv8 = 1'b0;
  logic [15:0] mc [32];
  int          slc = 0;
  logic [15:0] e_rdc = 16'h0000;
  logic        e_rvc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s step %0d: got %0h expected %0h", tag, n_step, got, exp);
  endtask

  task automatic chk8();
    chk("a.busy",   32'(busy_a), 32'(sl8 > 0));
    chk("a.rvalid", 32'(rv_a),   32'(e_rv8));
    chk("a.rdata",  32'(rd_a),   32'(e_rda));
    chk("b.busy",   32'(busy_b), 32'(sl8 > 0));
    chk("b.rvalid", 32'(rv_b),   32'(e_rv8));
    chk("b.rdata",  32'(rd_b),   32'(e_rdb));
  endtask

  task automatic chkc();
    chk("c.busy",   32'(busy_c), 32'(slc > 0));
    chk("c.rvalid", 32'(rv_c),   32'(e_rvc));
    chk("c.rdata",  32'(rd_c),   32'(e_rdc));
  endtask

  task automatic model8();
    logic [7:0] old;
    if (sl8 > 0) begin
      sl8--;
      e_rv8 = 1'b0;
    end else if (clr_a) begin
      sl8 = 8;
      foreach (m8[i]) m8[i] = 8'h00;
      e_rv8 = 1'b0;
    end else begin
      old = m8[ra_a];
      if (we_a) m8[wa_a] = wd_a;
      e_rv8 = re_a;
      if (re_a) begin
        e_rda = m8[ra_a];
        e_rdb = old;
      end
    end
  endtask

  task automatic modelc();
    if (slc > 0) begin
      slc--;
      e_rvc = 1'b0;
    end else if (clr_c) begin
      slc = 32;
      foreach (mc[i]) mc[i] = 16'h0000;
      e_rvc = 1'b0;
    end else begin
      if (we_c) mc[wa_c] = wd_c;
      e_rvc = re_c;
      if (re_c) e_rdc = mc[ra_c];
    end
  endtask

  task automatic step8(input logic c, input logic w, input logic [2:0] wa,
                       input logic [7:0] wd, input logic r, input logic [2:0] ra);
    clr_a = c; we_a = w; wa_a = wa; wd_a = wd; re_a = r; ra_a = ra;
    @(posedge clock);
    n_step++;
    model8();
    #1;
    chk8();
  endtask

  task automatic step8_rand();
    step8(1'($urandom_range(1)), 1'($urandom_range(1)), 3'($urandom_range(7)),
          8'($urandom), 1'($urandom_range(1)), 3'($urandom_range(7)));
  endtask

  task automatic stepc(input logic c, input logic w, input logic [4:0] wa,
                       input logic [15:0] wd, input logic r, input logic [4:0] ra);
    clr_c = c; we_c = w; wa_c = wa; wd_c = wd; re_c = r; ra_c = ra;
    @(posedge clock);
    n_step++;
    modelc();
    #1;
    chkc();
  endtask

  task automatic reset8_assert();
    rst_a = 1'b1;
    sl8   = 8;
    foreach (m8[i]) m8[i] = 8'h00;
    e_rda = 8'h00; e_rdb = 8'h00; e_rv8 = 1'b0;
    #1;
    chk8();
  endtask

  initial begin
    // Power-up reset, then the automatic sweep with junk on the ports
    #1;
    reset8_assert();
    @(negedge clock);
    rst_a = 1'b0;
    for (int i = 0; i < 8; i++) step8_rand();
    for (int i = 0; i < 8; i++) step8(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'(i));

    // Write then read back next cycle
    step8(1'b0, 1'b1, 3'd5, 8'hA5, 1'b0, 3'd0);
    step8(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd5);
    step8(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd5);

    // Same-address collision, then a follow-up read
    step8(1'b0, 1'b1, 3'd2, 8'h11, 1'b0, 3'd0);
    step8(1'b0, 1'b1, 3'd2, 8'h22, 1'b1, 3'd2);
    step8(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2);
    // Different addresses in the same cycle
    step8(1'b0, 1'b1, 3'd6, 8'h5C, 1'b1, 3'd5);

    // Fill with FF, clear with a competing write, sweep with junk, read back
    for (int i = 0; i < 8; i++) step8(1'b0, 1'b1, 3'(i), 8'hFF, 1'b0, 3'd0);
    step8(1'b1, 1'b1, 3'd1, 8'h33, 1'b1, 3'd1);
    for (int i = 0; i < 8; i++) step8(1'b0, 1'b1, 3'(i), 8'($urandom), 1'b1, 3'(i));
    for (int i = 0; i < 8; i++) step8(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'(i));

    // Reset in the middle of a sweep
    for (int i = 0; i < 8; i++) step8(1'b0, 1'b1, 3'(i), 8'hC3, 1'b0, 3'd0);
    step8(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
    for (int i = 0; i < 4; i++) step8_rand();
    #2;
    reset8_assert();
    @(posedge clock);
    #1;
    chk8();
    @(negedge clock);
    rst_a = 1'b0;
    for (int i = 0; i < 8; i++) step8_rand();
    step8(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd7);

    // Randomized traffic with occasional clears
    for (int i = 0; i < 300; i++) begin
      step8(($urandom_range(39) == 0), 1'($urandom_range(1)), 3'($urandom_range(7)),
            8'($urandom), 1'($urandom_range(1)), 3'($urandom_range(7)));
    end
    step8(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);

    // Wide/deep instance: full 32-cycle sweep, fill, continuous reads
    rst_c = 1'b1;
    slc   = 32;
    foreach (mc[i]) mc[i] = 16'h0000;
    e_rdc = 16'h0000; e_rvc = 1'b0;
    #1;
    chkc();
    @(negedge clock);
    rst_c = 1'b0;
    for (int i = 0; i < 32; i++) begin
      stepc(1'($urandom_range(1)), 1'b1, 5'($urandom_range(31)), 16'($urandom),
            1'b1, 5'($urandom_range(31)));
    end
    for (int i = 0; i < 32; i++) stepc(1'b0, 1'b1, 5'(i), 16'(i * 3), 1'b0, 5'd0);
    for (int i = 0; i < 32; i++) stepc(1'b0, 1'b0, 5'd0, 16'h0000, 1'b1, 5'(i));
    stepc(1'b0, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0);
    for (int i = 0; i < 60; i++) begin
      stepc(($urandom_range(29) == 0), 1'($urandom_range(1)), 5'($urandom_range(31)),
            16'($urandom), 1'($urandom_range(1)), 5'($urandom_range(31)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
